// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Purpose  : Shared constants and enums for the instruction-memory arbiter.
// Revision : 1.0
// ============================================================================
package imem_pkg;

    localparam int IMEM_DEPTH  = 1024;
    localparam int IMEM_DATA_W = 64;
    localparam int IMEM_ADDR_W = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        ERR   = 2'd3
    } state_t;

    typedef enum logic {
        OP_WRITE = 1'b0,
        OP_READ  = 1'b1
    } op_t;

    typedef enum logic {
        REQ_LOADER = 1'b0,
        REQ_FETCH  = 1'b1
    } req_t;

endpackage
`default_nettype wire

// File: rtl/imem_access_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_access_arbiter_if
// Purpose  : Loader, fetch and memory-port signals of the imem arbiter.
// Revision : 1.0
// ============================================================================
interface imem_access_arbiter_if
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_done;
    logic              ld_gnt;
    logic              ld_err;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              if_err;

    logic              booted;

    logic              mem_enable;
    logic              mem_read;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    // Arbiter side
    modport slave (
        input  ld_req, ld_addr, ld_data, ld_done, if_req, if_addr, mem_data_out,
        output ld_gnt, ld_err, if_gnt, if_rvalid, if_rdata, if_err, booted,
               mem_enable, mem_read, mem_address, mem_data_in
    );

    // Requester / memory side
    modport master (
        output ld_req, ld_addr, ld_data, ld_done, if_req, if_addr, mem_data_out,
        input  ld_gnt, ld_err, if_gnt, if_rvalid, if_rdata, if_err, booted,
               mem_enable, mem_read, mem_address, mem_data_in
    );

endinterface
`default_nettype wire

// File: rtl/imem_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : imem_rr_arb
// Purpose  : 2-way round-robin arbiter with per-requester enable mask.
// Revision : 1.0
// ============================================================================
module imem_rr_arb
    import imem_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       reset,
    input  wire logic       i_go,     // arbitration allowed this cycle
    input  wire logic [1:0] i_req,    // [0] loader, [1] fetch
    input  wire logic [1:0] i_en,
    output logic      [1:0] o_gnt
);

    req_t       r_rr_last;
    logic [1:0] w_act;

    always_comb begin
        w_act = i_req & i_en & {2{i_go}};
        o_gnt = 2'b00;
        case (w_act)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            // Contention goes to whoever was not served last
            2'b11:   o_gnt = (r_rr_last == REQ_FETCH) ? 2'b01 : 2'b10;
            default: o_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_last <= REQ_FETCH;
        end else if (o_gnt[0]) begin
            r_rr_last <= REQ_LOADER;
        end else if (o_gnt[1]) begin
            r_rr_last <= REQ_FETCH;
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_access_arbiter
// Purpose  : Shares the instruction memory port between loader and fetch,
//            gating fetch until boot completes and range-checking addresses.
// Revision : 1.0
// ============================================================================
module imem_access_arbiter
    import imem_pkg::*;
#(
    parameter int DATA_W = IMEM_DATA_W,
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  wire logic             clk,
    input  wire logic             reset,
    imem_access_arbiter_if.slave  bus
);

    localparam logic [ADDR_W-1:0] c_DEPTH_LIMIT = ADDR_W'(DEPTH);

    state_t            r_state;
    state_t            w_state_next;
    logic              r_booted;
    op_t               r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_gnt;
    logic              w_go;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_oob;

    // Grants are suppressed while reset is high so no accepted request is lost
    assign w_go = (r_state == IDLE) && !reset;

    imem_rr_arb u_arb (
        .clk   (clk),
        .reset (reset),
        .i_go  (w_go),
        .i_req ({bus.if_req, bus.ld_req}),
        .i_en  ({r_booted, 1'b1}),
        .o_gnt (w_gnt)
    );

    always_comb begin
        w_sel_addr      = w_gnt[1] ? bus.if_addr : bus.ld_addr;
        w_sel_oob       = (w_sel_addr >= c_DEPTH_LIMIT);
        w_state_next    = r_state;

        bus.ld_gnt      = w_gnt[0];
        bus.if_gnt      = w_gnt[1];
        bus.ld_err      = 1'b0;
        bus.if_err      = 1'b0;
        bus.if_rvalid   = 1'b0;
        bus.if_rdata    = r_rdata;
        bus.booted      = r_booted;
        bus.mem_enable  = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_address = '0;
        bus.mem_data_in = '0;

        case (r_state)
            IDLE: begin
                if (|w_gnt) begin
                    w_state_next = w_sel_oob ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                bus.mem_enable  = 1'b1;
                bus.mem_read    = (r_op == OP_READ);
                bus.mem_address = r_addr;
                bus.mem_data_in = (r_op == OP_WRITE) ? r_data : '0;
                w_state_next    = (r_op == OP_READ) ? RESP : IDLE;
            end
            RESP: begin
                // Present memory data in the same cycle; the register keeps it afterwards
                bus.if_rvalid = 1'b1;
                bus.if_rdata  = bus.mem_data_out;
                w_state_next  = IDLE;
            end
            ERR: begin
                bus.ld_err   = (r_op == OP_WRITE);
                bus.if_err   = (r_op == OP_READ);
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_booted <= 1'b0;
            r_op     <= OP_WRITE;
            r_addr   <= '0;
            r_data   <= '0;
            r_rdata  <= '0;
        end else begin
            r_state <= w_state_next;
            if (bus.ld_done) begin
                r_booted <= 1'b1;
            end
            if (|w_gnt) begin
                r_op   <= w_gnt[1] ? OP_READ : OP_WRITE;
                r_addr <= w_sel_addr;
                r_data <= bus.ld_data;
            end
            if (r_state == RESP) begin
                r_rdata <= bus.mem_data_out;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_access_arbiter
// Purpose  : Directed and randomized checks of imem_access_arbiter against a
//            transaction-level reference memory.
// Revision : 1.0
// ============================================================================
module tb_imem_access_arbiter;

    logic clk;
    logic reset;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [63:0] tb_mem  [0:1023];
    logic [63:0] ref_mem [int];

    imem_access_arbiter_if bus ();

    imem_access_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read memory attached to the controller's port
    always @(posedge clk) begin
        if (bus.mem_enable) begin
            if (bus.mem_read) bus.mem_data_out <= tb_mem[bus.mem_address[9:0]];
            else              tb_mem[bus.mem_address[9:0]] <= bus.mem_data_in;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [63:0] ref_rd(input logic [63:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return 64'd0;
    endfunction

    function automatic logic [63:0] rnd64();
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctrl"}, {56'd0, bus.ld_gnt, bus.ld_err, bus.if_gnt, bus.if_rvalid,
                             bus.if_err, bus.booted, bus.mem_enable, bus.mem_read}, 64'd0);
        chk({tag, "_maddr"}, bus.mem_address, 64'd0);
        chk({tag, "_mdin"},  bus.mem_data_in, 64'd0);
        chk({tag, "_rdata"}, bus.if_rdata,    64'd0);
    endtask

    task automatic do_load(input logic [63:0] a, input logic [63:0] d);
        int   k;
        logic oob;
        oob = (a >= 64'd1024);
        tick();
        bus.ld_req  = 1'b1;
        bus.ld_addr = a;
        bus.ld_data = d;
        settle();
        k = 0;
        while (bus.ld_gnt !== 1'b1 && k < 20) begin
            tick(); settle(); k++;
        end
        chk("ld_gnt", {63'd0, bus.ld_gnt}, 64'd1);
        chk("ld_gnt_if_quiet", {63'd0, bus.if_gnt}, 64'd0);
        tick();
        bus.ld_req = 1'b0;
        settle();
        if (oob) begin
            chk("ld_err", {63'd0, bus.ld_err}, 64'd1);
            chk("ld_err_no_mem", {63'd0, bus.mem_enable}, 64'd0);
        end else begin
            chk("ld_mem_en",   {63'd0, bus.mem_enable}, 64'd1);
            chk("ld_mem_rd",   {63'd0, bus.mem_read},   64'd0);
            chk("ld_mem_addr", bus.mem_address, a);
            chk("ld_mem_din",  bus.mem_data_in, d);
            chk("ld_no_err",   {63'd0, bus.ld_err}, 64'd0);
            ref_mem[int'(a)] = d;
        end
        tick(); settle();
        chk("ld_after_mem", {63'd0, bus.mem_enable}, 64'd0);
        chk("ld_after_err", {63'd0, bus.ld_err},     64'd0);
    endtask

    task automatic do_fetch(input logic [63:0] a);
        int   k;
        logic oob;
        oob = (a >= 64'd1024);
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        settle();
        k = 0;
        while (bus.if_gnt !== 1'b1 && k < 20) begin
            tick(); settle(); k++;
        end
        chk("if_gnt", {63'd0, bus.if_gnt}, 64'd1);
        tick();
        bus.if_req = 1'b0;
        settle();
        if (oob) begin
            chk("if_err", {63'd0, bus.if_err}, 64'd1);
            chk("if_err_no_mem", {63'd0, bus.mem_enable}, 64'd0);
        end else begin
            chk("if_mem_en",   {63'd0, bus.mem_enable}, 64'd1);
            chk("if_mem_rd",   {63'd0, bus.mem_read},   64'd1);
            chk("if_mem_addr", bus.mem_address, a);
        end
        tick(); settle();
        if (oob) begin
            chk("if_err_no_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
            chk("if_err_done",      {63'd0, bus.if_err},    64'd0);
        end else begin
            chk("if_rvalid", {63'd0, bus.if_rvalid}, 64'd1);
            chk("if_rdata",  bus.if_rdata, ref_rd(a));
        end
    endtask

    initial begin
        logic [63:0] ra;
        logic [63:0] wdata;
        logic [63:0] rv_exp;
        int          busy;
        int          rv_at;
        logic        nxt_if;
        logic        chg;
        logic        exp_ld;
        logic        exp_if;

        for (int i = 0; i < 1024; i++) tb_mem[i] = 64'd0;
        reset       = 1'b1;
        bus.ld_req  = 1'b0;
        bus.ld_addr = '0;
        bus.ld_data = '0;
        bus.ld_done = 1'b0;
        bus.if_req  = 1'b0;
        bus.if_addr = '0;

        // Reset state
        tick(); tick(); settle();
        chk_all_zero("rst_hold");
        tick(); reset = 1'b0; settle();
        chk_all_zero("rst_rel");

        // Fetch locked out during boot
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 64'd5;
        settle();
        for (int i = 0; i < 10; i++) begin
            chk("boot_if_gnt",  {63'd0, bus.if_gnt},     64'd0);
            chk("boot_mem_en",  {63'd0, bus.mem_enable}, 64'd0);
            chk("boot_booted",  {63'd0, bus.booted},     64'd0);
            tick(); settle();
        end

        // Loads during boot while fetch is still held
        do_load(64'd3, 64'hDEAD_BEEF);
        do_load(64'd0, rnd64());
        do_load(64'd1023, rnd64());
        for (int i = 0; i < 5; i++) do_load(64'($urandom_range(0, 31)), rnd64());
        do_load(64'hFFFF_FFFF_FFFF_FFFF, rnd64());

        tick();
        bus.if_req  = 1'b0;
        bus.ld_done = 1'b1;
        settle();
        chk("boot_before_done", {63'd0, bus.booted}, 64'd0);
        tick();
        bus.ld_done = 1'b0;
        settle();
        chk("boot_after_done", {63'd0, bus.booted}, 64'd1);

        // Run-phase fetches incl. boundaries and hold of read data
        do_fetch(64'd3);
        chk("fetch3_value", bus.if_rdata, 64'hDEAD_BEEF);
        tick(); settle();
        chk("rdata_hold_rvalid", {63'd0, bus.if_rvalid}, 64'd0);
        chk("rdata_hold_value",  bus.if_rdata, 64'hDEAD_BEEF);
        do_fetch(64'd1023);
        do_fetch(64'd0);
        do_fetch(64'd1024);

        // Round robin with both requesters held; last grant went to fetch
        ra    = 64'($urandom_range(0, 1023));
        wdata = rnd64();
        tick();
        bus.ld_req  = 1'b1;
        bus.if_req  = 1'b1;
        bus.ld_addr = ra;
        bus.if_addr = ra;
        bus.ld_data = wdata;
        settle();
        busy   = 0;
        nxt_if = 1'b0;
        rv_at  = -1;
        rv_exp = '0;
        chg    = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (c > 0) begin
                tick();
                if (chg) begin
                    wdata       = rnd64();
                    bus.ld_data = wdata;
                    chg         = 1'b0;
                end
                settle();
            end
            exp_ld = (busy == 0) && !nxt_if;
            exp_if = (busy == 0) &&  nxt_if;
            chk("rr_ld_gnt", {63'd0, bus.ld_gnt},    {63'd0, exp_ld});
            chk("rr_if_gnt", {63'd0, bus.if_gnt},    {63'd0, exp_if});
            chk("rr_rvalid", {63'd0, bus.if_rvalid}, {63'd0, (c == rv_at)});
            if (c == rv_at) chk("rr_rdata", bus.if_rdata, rv_exp);
            if (exp_ld) begin
                ref_mem[int'(ra)] = wdata;
                busy   = 2;
                nxt_if = 1'b1;
                chg    = 1'b1;
            end else if (exp_if) begin
                rv_exp = ref_rd(ra);
                rv_at  = c + 2;
                busy   = 3;
                nxt_if = 1'b0;
            end
            if (busy > 0) busy--;
        end
        tick();
        bus.ld_req = 1'b0;
        bus.if_req = 1'b0;
        settle();
        for (int i = 0; i < 4; i++) tick();

        // Randomized single-requester traffic
        for (int i = 0; i < 30; i++) begin
            logic [63:0] a;
            if ($urandom_range(0, 5) == 0) a = rnd64() | 64'h400;
            else                           a = 64'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) do_fetch(a);
            else                           do_load(a, rnd64());
        end

        // Reset during the ISSUE cycle of a fetch
        ra = 64'($urandom_range(0, 31));
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = ra;
        settle();
        chk("mid_rst_gnt", {63'd0, bus.if_gnt}, 64'd1);
        tick();
        reset = 1'b1;
        settle();
        chk("mid_rst_issue", {63'd0, bus.mem_enable}, 64'd1);
        tick();
        reset = 1'b0;
        settle();
        chk_all_zero("mid_rst");
        for (int i = 0; i < 5; i++) begin
            tick(); settle();
            chk("post_rst_if_gnt", {63'd0, bus.if_gnt},     64'd0);
            chk("post_rst_rvalid", {63'd0, bus.if_rvalid},  64'd0);
            chk("post_rst_mem_en", {63'd0, bus.mem_enable}, 64'd0);
        end
        bus.if_req = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_access_arbiter.md
Name: imem_access_arbiter

Overview:
- Controller that owns the 1024 x 64-bit instruction memory port (enable/read/address/data_in/data_out, registered read).
- Shares that port between a program loader (writes) and the instruction fetch unit (reads).
- Sequences boot: fetch is locked out until the loader signals completion.
- Range-checks addresses and returns read data with a valid strobe.

Parameters:
- DATA_W, 64, memory word width
- ADDR_W, 64, address width on all ports
- DEPTH, 1024, number of memory words; legal addresses are 0..DEPTH-1

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ld_req  in  1  loader write request; held until ld_gnt
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader write data
- ld_done  in  1  one-cycle pulse: program load complete
- ld_gnt  out  1  one-cycle pulse: loader request accepted
- ld_err  out  1  one-cycle pulse: loader address out of range, no write
- if_req  in  1  fetch read request; held until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  read data
- if_err  out  1  one-cycle pulse: fetch address out of range, no read
- booted  out  1  high once ld_done has been seen
- mem_enable  out  1  memory enable
- mem_read  out  1  1 = read, 0 = write
- mem_address  out  ADDR_W  memory address
- mem_data_in  out  DATA_W  memory write data
- mem_data_out  in  DATA_W  memory read data; valid the cycle after an enabled read edge

Behaviour:
- Clock is clk; reset is synchronous and active-high. All state changes occur on the rising edge of clk.
- Reset values: state BOOT-IDLE, booted=0, rr_last=fetch, and every output 0, including mem_* and if_rdata.
- Reset mid-operation aborts the operation. mem_enable is 0 from the cycle after reset is sampled. Pending responses are dropped with no rvalid or err.
- Boot phase (booted=0): only the loader is served. if_req is ignored, and the requester keeps holding it.
- ld_done sampled high sets booted=1 permanently, until reset. ld_done in the same cycle as an ld_req grant: the request is still served.
- Run phase (booted=1): round-robin arbitration between ld_req and if_req.
  - Simultaneous requests are granted to the requester not granted last. rr_last updates on every grant.
  - A single requester is granted immediately.
- FSM states and transitions:
  - IDLE: select a requester, latch op, address and data, and pulse its gnt.
    - If addr >= DEPTH, go to ERR.
    - Otherwise go to ISSUE.
  - ISSUE: mem_enable=1, mem_read=op, mem_address and mem_data_in from the latches.
    - Write: go to IDLE.
    - Read: go to RESP.
  - RESP: if_rvalid=1, if_rdata = mem_data_out, captured into a register; go to IDLE. if_rdata holds its value until the next RESP.
  - ERR: pulse the corresponding err; mem_enable stays 0; go to IDLE.
- Latency from gnt cycle N:
  - Memory edge at the end of N+1.
  - Read data with if_rvalid in N+2.
  - Throughput: one write per 2 cycles, one read per 3 cycles.
- No new grant outside IDLE. Requests arriving then wait.
- Address compare is full ADDR_W unsigned. mem_address is passed through without truncation.
- mem_enable is never asserted in BOOT for a fetch, never for an out-of-range address, and never for more than one cycle per grant.

Decomposition:
- Shared package imem_pkg:
  - IMEM_DEPTH, IMEM_DATA_W, IMEM_ADDR_W
  - FSM state enum {IDLE, ISSUE, RESP, ERR}
  - op enum {OP_WRITE, OP_READ}
- Sub-module imem_rr_arb: 2-way round-robin arbiter with enable mask (fetch masked while booted=0). It outputs a one-hot grant and updates rr_last.
- FSM and datapath latches stay in imem_access_arbiter.

Test Plan:
- Fetch blocked at boot: reset, then if_req=1, if_addr=5 for 10 cycles -> if_gnt=0 and mem_enable=0 throughout; booted=0.
- Load and boot: ld_req with addr=3, data=0xDEAD_BEEF -> ld_gnt at N; mem_enable=1 and mem_read=0 at N+1 with mem_address=3. Then ld_done pulse -> booted=1 next cycle.
- Fetch read with the memory model attached, after loading addr 3: if_req with addr=3 -> if_gnt at N, mem_read=1 at N+1, if_rvalid=1 and if_rdata=0xDEAD_BEEF at N+2.
- Round-robin: both requesters held continuously after boot, with the last grant to fetch -> grants alternate loader, fetch, loader, ... No two grants are closer than 2 cycles, and none overlaps RESP.
- Out of range: if_addr=1024 -> if_gnt, then if_err at N+1, no mem_enable, no if_rvalid. Same check for ld_addr=0xFFFF_FFFF_FFFF_FFFF -> ld_err.
- Reset mid-read: assert reset in the ISSUE cycle of a fetch -> no if_rvalid, all outputs 0 next cycle, booted=0, and fetch is blocked again.
